// File: rtl/mcpu_mem_pkg.sv
// Shared constants and command-slot record for the LPDDR2 client arbiter.
package mcpu_mem_pkg;
  localparam int MEM_ADDR_W = 25;
  localparam int MEM_DATA_W = 128;
  localparam int MEM_BE_W   = 16;
  localparam logic [4:0] MEM_SIZE_ONE = 5'd1;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_cmd_t;
endpackage

// File: rtl/mcpu_mem_arb_tagfifo.sv
// In-order FIFO of client IDs for reads issued to the controller.
module mcpu_mem_arb_tagfifo #(
  parameter int ID_W     = 2,
  parameter int RD_DEPTH = 8,
  localparam int PTR_W   = $clog2(RD_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty,
  output logic [CNT_W-1:0] count
);
  logic [ID_W-1:0]  mem_q [RD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(RD_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head_id = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end
endmodule

// File: rtl/mcpu_mem_arb.sv
// Round-robin arbiter of single-beat client requests onto the controller's
// Avalon command port, with in-order steering of read returns.
module mcpu_mem_arb
  import mcpu_mem_pkg::*;
#(
  parameter int NCLIENTS = 4,
  parameter int RD_DEPTH = 8
) (
  input  logic                           clkrst_avl_clk,
  input  logic                           clkrst_avl_rst,
  input  logic                           mc_ready,
  input  logic [NCLIENTS-1:0]            cli_valid,
  output logic [NCLIENTS-1:0]            cli_ready,
  input  logic [NCLIENTS-1:0]            cli_write,
  input  logic [NCLIENTS*MEM_ADDR_W-1:0] cli_addr,
  input  logic [NCLIENTS*MEM_DATA_W-1:0] cli_wdata,
  input  logic [NCLIENTS*MEM_BE_W-1:0]   cli_be,
  output logic [MEM_DATA_W-1:0]          cli_rdata,
  output logic [NCLIENTS-1:0]            cli_rdata_valid,
  output logic [MEM_ADDR_W-1:0]          arb2mc_avl_addr_0,
  output logic [MEM_DATA_W-1:0]          arb2mc_avl_wdata_0,
  output logic [MEM_BE_W-1:0]            arb2mc_avl_be_0,
  output logic                           arb2mc_avl_read_req_0,
  output logic                           arb2mc_avl_write_req_0,
  output logic                           arb2mc_avl_burstbegin_0,
  output logic [4:0]                     arb2mc_avl_size_0,
  input  logic                           arb2mc_avl_ready_0,
  input  logic                           arb2mc_avl_rdata_valid_0,
  input  logic [MEM_DATA_W-1:0]          arb2mc_avl_rdata_0,
  output logic                           arb_err
);
  localparam int ID_W  = $clog2(NCLIENTS);
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  mem_cmd_t                slot_q, slot_d;
  logic                    slot_vld_q, slot_vld_d;
  logic [ID_W-1:0]         rr_q, rr_d, gidx;
  logic [NCLIENTS-1:0]     elig, grant, rvalid_q, rvalid_d;
  logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    slot_free, rd_room, found;
  logic [ID_W:0]           sum;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]         fifo_head;
  logic [CNT_W-1:0]        fifo_cnt;

  // Reads are pushed at load time, so the FIFO count already covers a read held in the slot.
  assign slot_free = ~slot_vld_q | arb2mc_avl_ready_0;
  assign rd_room   = (fifo_cnt < CNT_W'(RD_DEPTH));

  always_comb begin
    for (int i = 0; i < NCLIENTS; i++)
      elig[i] = cli_valid[i] & mc_ready & slot_free & (cli_write[i] | rd_room);
  end

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    for (int j = 0; j < NCLIENTS; j++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(j);
      if (sum >= (ID_W+1)'(NCLIENTS)) sum = sum - (ID_W+1)'(NCLIENTS);
      if (!found && elig[sum[ID_W-1:0]]) begin
        grant[sum[ID_W-1:0]] = 1'b1;
        gidx  = sum[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign cli_ready = grant;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    rr_d       = rr_q;
    if (slot_vld_q && arb2mc_avl_ready_0) slot_vld_d = 1'b0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (grant[i]) begin
        slot_vld_d   = 1'b1;
        slot_d.write = cli_write[i];
        slot_d.addr  = cli_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
        slot_d.wdata = cli_wdata[i*MEM_DATA_W +: MEM_DATA_W];
        slot_d.be    = cli_be[i*MEM_BE_W +: MEM_BE_W];
      end
    end
    if (found) rr_d = (gidx == ID_W'(NCLIENTS-1)) ? '0 : gidx + 1'b1;
    fifo_push = found & ~slot_d.write & ~fifo_full;
  end

  // A return with no recorded read is a protocol error; it is flagged, never steered.
  always_comb begin
    fifo_pop = arb2mc_avl_rdata_valid_0 & ~fifo_empty;
    err_d    = err_q | (arb2mc_avl_rdata_valid_0 & fifo_empty);
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (fifo_pop) begin
      rvalid_d[fifo_head] = 1'b1;
      rdata_d             = arb2mc_avl_rdata_0;
    end
  end

  always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
    if (clkrst_avl_rst) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      rr_q       <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      rr_q       <= rr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  mcpu_mem_arb_tagfifo #(.ID_W(ID_W), .RD_DEPTH(RD_DEPTH)) u_tagfifo (
    .clk     (clkrst_avl_clk),
    .rst     (clkrst_avl_rst),
    .push    (fifo_push),
    .push_id (gidx),
    .pop     (fifo_pop),
    .head_id (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign arb2mc_avl_addr_0       = slot_q.addr;
  assign arb2mc_avl_wdata_0      = slot_q.wdata;
  assign arb2mc_avl_be_0         = slot_q.be;
  assign arb2mc_avl_read_req_0   = slot_vld_q & ~slot_q.write;
  assign arb2mc_avl_write_req_0  = slot_vld_q & slot_q.write;
  assign arb2mc_avl_burstbegin_0 = slot_vld_q;
  assign arb2mc_avl_size_0       = MEM_SIZE_ONE;
  assign cli_rdata               = rdata_q;
  assign cli_rdata_valid         = rvalid_q;
  assign arb_err                 = err_q;
endmodule

// File: tb/tb_mcpu_mem_arb.sv
// Scenario bench for mcpu_mem_arb: read tags and expected returns go through queues.
module tb_mcpu_mem_arb;
  localparam int NC = 4;

  typedef struct {
    logic [NC-1:0] strobe;
    logic [127:0]  data;
  } resp_t;
  typedef struct {
    logic [24:0]  addr;
    logic [127:0] wdata;
  } cmd_t;

  logic clk = 1'b0, rst = 1'b1, mc_ready = 1'b0;
  logic [NC-1:0]     cli_valid = '0, cli_write = '0, cli_ready, cli_rdata_valid;
  logic [NC*25-1:0]  cli_addr = '0;
  logic [NC*128-1:0] cli_wdata = '0;
  logic [NC*16-1:0]  cli_be = '0;
  logic [127:0]      cli_rdata;
  logic [24:0]       avl_addr;
  logic [127:0]      avl_wdata, avl_rdata = '0;
  logic [15:0]       avl_be;
  logic              avl_rd, avl_wr, avl_bb, avl_ready = 1'b0, avl_rvalid = 1'b0, arb_err;
  logic [4:0]        avl_size;

  int    n_tests = 0, n_fail = 0;
  int    tag_q[$];
  resp_t resp_q[$];
  cmd_t  cmd_q[$];

  mcpu_mem_arb #(.NCLIENTS(NC), .RD_DEPTH(8)) dut (
    .clkrst_avl_clk(clk), .clkrst_avl_rst(rst), .mc_ready(mc_ready),
    .cli_valid(cli_valid), .cli_ready(cli_ready), .cli_write(cli_write),
    .cli_addr(cli_addr), .cli_wdata(cli_wdata), .cli_be(cli_be),
    .cli_rdata(cli_rdata), .cli_rdata_valid(cli_rdata_valid),
    .arb2mc_avl_addr_0(avl_addr), .arb2mc_avl_wdata_0(avl_wdata), .arb2mc_avl_be_0(avl_be),
    .arb2mc_avl_read_req_0(avl_rd), .arb2mc_avl_write_req_0(avl_wr),
    .arb2mc_avl_burstbegin_0(avl_bb), .arb2mc_avl_size_0(avl_size),
    .arb2mc_avl_ready_0(avl_ready), .arb2mc_avl_rdata_valid_0(avl_rvalid),
    .arb2mc_avl_rdata_0(avl_rdata), .arb_err(arb_err)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    cli_valid = '0; cli_write = '0; avl_rvalid = 1'b0; avl_rdata = '0;
  endtask

  task automatic apply_reset;
    rst = 1'b1; idle();
    tag_q.delete(); resp_q.delete(); cmd_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [24:0] a,
                         input logic [127:0] d, input logic [15:0] be);
    cli_write[i] = wr;
    cli_addr[i*25 +: 25] = a;
    cli_wdata[i*128 +: 128] = d;
    cli_be[i*16 +: 16] = be;
  endtask

  // Drives one read return; the expected strobe comes from the oldest issued tag.
  task automatic drive_rdata(input logic [127:0] d);
    resp_t r;
    avl_rvalid = 1'b1; avl_rdata = d;
    if (tag_q.size() > 0) begin
      r.strobe = NC'(1) << tag_q.pop_front();
      r.data = d;
      resp_q.push_back(r);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(); mc_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({avl_rd, avl_wr, avl_bb, arb_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {avl_rd, avl_wr, avl_bb, arb_err}); end
    n_tests++; if (avl_size !== 5'd1) begin n_fail++; $display("FAIL reset_size: got %0d want 1", avl_size); end
    n_tests++; if (avl_addr !== 25'd0 || cli_rdata !== 128'd0 || cli_rdata_valid !== 4'b0) begin n_fail++; $display("FAIL reset_data: addr %h rdata %h rv %b want zero", avl_addr, cli_rdata, cli_rdata_valid); end
    #1 rst = 1'b0;
    tick();
    set_req(0, 1'b1, 25'h1, '0, '1); cli_valid = 4'b0001; avl_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0000) begin n_fail++; $display("FAIL mc_ready_low: got %b want 0000", cli_ready); end
    tick(); idle();
  endtask

  task automatic test_single_read;
    resp_t r;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b1;
    set_req(0, 1'b0, 25'h000123, '0, '0); cli_valid = 4'b0001;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0001) begin n_fail++; $display("FAIL rd_grant: got %b want 0001", cli_ready); end
    tag_q.push_back(0);
    tick(); cli_valid = '0;
    @(negedge clk);
    n_tests++; if ({avl_rd, avl_wr, avl_bb} !== 3'b101 || avl_addr !== 25'h000123 || avl_size !== 5'd1) begin n_fail++; $display("FAIL rd_cmd: rd/wr/bb %b addr %h size %0d want 101 000123 1", {avl_rd, avl_wr, avl_bb}, avl_addr, avl_size); end
    tick();
    @(negedge clk);
    n_tests++; if (avl_rd !== 1'b0) begin n_fail++; $display("FAIL rd_accepted: read_req %b want 0", avl_rd); end
    repeat (8) tick();
    drive_rdata({16{8'hA5}});
    @(negedge clk);
    n_tests++; if (cli_rdata_valid !== 4'b0) begin n_fail++; $display("FAIL rd_latency: got %b want 0000", cli_rdata_valid); end
    tick(); avl_rvalid = 1'b0;
    @(negedge clk);
    r = resp_q.pop_front();
    n_tests++; if (cli_rdata_valid !== r.strobe || cli_rdata !== r.data) begin n_fail++; $display("FAIL rd_return: rv %b data %h want %b %h", cli_rdata_valid, cli_rdata, r.strobe, r.data); end
    tick();
  endtask

  task automatic test_round_robin;
    cmd_t c;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b1;
    for (int i = 0; i < NC; i++) set_req(i, 1'b1, 25'h100 + 25'(i), {4{32'(i) + 32'hC0DE0000}}, '1);
    cli_valid = 4'b1111;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        c = cmd_q.pop_front();
        n_tests++; if (avl_wr !== 1'b1 || avl_addr !== c.addr || avl_wdata !== c.wdata) begin n_fail++; $display("FAIL rr_cmd%0d: wr %b addr %h want 1 %h", k, avl_wr, avl_addr, c.addr); end
      end
      if (k < 8) begin
        n_tests++; if (cli_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, cli_ready, 4'b0001 << (k % 4)); end
        c.addr = 25'h100 + 25'(k % 4); c.wdata = {4{32'(k % 4) + 32'hC0DE0000}};
        cmd_q.push_back(c);
      end else begin
        n_tests++; if (cli_ready !== 4'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0000", cli_ready); end
      end
      tick();
      if (k == 7) cli_valid = '0;
    end
  endtask

  task automatic test_hold;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b0;
    set_req(1, 1'b1, 25'h1ABCDE, {4{32'hDEADBEEF}}, 16'h0F0F);
    set_req(2, 1'b1, 25'h0002A, {4{32'h12345678}}, 16'hFFFF);
    cli_valid = 4'b0010;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_grant: got %b want 0010", cli_ready); end
    tick(); cli_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({avl_rd, avl_wr} !== 2'b01 || avl_addr !== 25'h1ABCDE || avl_wdata !== {4{32'hDEADBEEF}} || avl_be !== 16'h0F0F || cli_ready !== 4'b0) begin
        n_fail++; $display("FAIL hold_cyc%0d: rd/wr %b addr %h be %h ready %b want 01 1abcde 0f0f 0000", k, {avl_rd, avl_wr}, avl_addr, avl_be, cli_ready);
      end
      tick();
    end
    avl_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0100 || avl_addr !== 25'h1ABCDE) begin n_fail++; $display("FAIL hold_release: ready %b addr %h want 0100 1abcde", cli_ready, avl_addr); end
    tick(); cli_valid = '0;
    @(negedge clk);
    n_tests++; if (avl_wr !== 1'b1 || avl_addr !== 25'h0002A || avl_be !== 16'hFFFF) begin n_fail++; $display("FAIL hold_next: wr %b addr %h want 1 0002a", avl_wr, avl_addr); end
    tick();
  endtask

  task automatic test_full;
    resp_t r;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b1;
    set_req(0, 1'b0, 25'h40, '0, '0);
    set_req(1, 1'b1, 25'h41, {4{32'h5A5A5A5A}}, '1);
    cli_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++; if (cli_ready !== 4'b0001) begin n_fail++; $display("FAIL full_rd%0d: got %b want 0001", k, cli_ready); end
      tag_q.push_back(0);
      tick();
    end
    cli_valid = 4'b0011;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0010) begin n_fail++; $display("FAIL full_wr_grant: got %b want 0010", cli_ready); end
    tick(); cli_valid = 4'b0001;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0000) begin n_fail++; $display("FAIL full_blocked: got %b want 0000", cli_ready); end
    tick(); drive_rdata({8{16'h0900}});
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0000) begin n_fail++; $display("FAIL full_pop_cycle: got %b want 0000", cli_ready); end
    tick(); avl_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0001) begin n_fail++; $display("FAIL full_regrant: got %b want 0001", cli_ready); end
    tag_q.push_back(0);
    r = resp_q.pop_front();
    n_tests++; if (cli_rdata_valid !== r.strobe || cli_rdata !== r.data) begin n_fail++; $display("FAIL full_ret0: rv %b data %h want %b %h", cli_rdata_valid, cli_rdata, r.strobe, r.data); end
    tick(); cli_valid = '0;
    for (int k = 0; k < 8; k++) begin
      drive_rdata({4{32'(k) + 32'hF00D0000}});
      tick();
      @(negedge clk);
      if (resp_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL full_drain%0d: no expected response queued", k);
      end else begin
        r = resp_q.pop_front();
        n_tests++; if (cli_rdata_valid !== r.strobe || cli_rdata !== r.data) begin n_fail++; $display("FAIL full_drain%0d: rv %b data %h want %b %h", k, cli_rdata_valid, cli_rdata, r.strobe, r.data); end
      end
    end
    avl_rvalid = 1'b0;
    tick();
    n_tests++; if (arb_err !== 1'b0) begin n_fail++; $display("FAIL full_no_err: got %b want 0", arb_err); end
  endtask

  task automatic test_back_to_back;
    resp_t r;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b1;
    set_req(2, 1'b0, 25'h20, '0, '0);
    set_req(0, 1'b0, 25'h10, '0, '0);
    set_req(3, 1'b0, 25'h30, '0, '0);
    cli_valid = 4'b0100;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0100) begin n_fail++; $display("FAIL il_grant2: got %b want 0100", cli_ready); end
    tag_q.push_back(2);
    tick(); cli_valid = 4'b0001;
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b0001) begin n_fail++; $display("FAIL il_grant0: got %b want 0001", cli_ready); end
    tag_q.push_back(0);
    tick(); cli_valid = 4'b1000; drive_rdata({4{32'hAAAA0002}});
    @(negedge clk);
    n_tests++; if (cli_ready !== 4'b1000) begin n_fail++; $display("FAIL il_grant3: got %b want 1000", cli_ready); end
    tag_q.push_back(3);
    n_tests++; if (dut.fifo_cnt !== 4'd2) begin n_fail++; $display("FAIL il_cnt_before: got %0d want 2", dut.fifo_cnt); end
    tick(); cli_valid = '0; drive_rdata({4{32'hBBBB0000}});
    @(negedge clk);
    n_tests++; if (dut.fifo_cnt !== 4'd2) begin n_fail++; $display("FAIL il_cnt_pushpop: got %0d want 2", dut.fifo_cnt); end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        // already sampled this cycle
      end else begin
        @(negedge clk);
      end
      r = resp_q.pop_front();
      n_tests++; if (cli_rdata_valid !== r.strobe || cli_rdata !== r.data) begin n_fail++; $display("FAIL il_ret%0d: rv %b data %h want %b %h", k, cli_rdata_valid, cli_rdata, r.strobe, r.data); end
      tick();
      if (k == 0) drive_rdata({4{32'hCCCC0003}});
      else avl_rvalid = 1'b0;
    end
    @(negedge clk);
    n_tests++; if (dut.fifo_cnt !== 4'd0 || cli_rdata_valid !== 4'b0) begin n_fail++; $display("FAIL il_drained: cnt %0d rv %b want 0 0000", dut.fifo_cnt, cli_rdata_valid); end
    tick();
  endtask

  task automatic test_err_and_reset;
    apply_reset(); mc_ready = 1'b1; avl_ready = 1'b1;
    drive_rdata({4{32'hE0E0E0E0}});
    tick(); avl_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (arb_err !== 1'b1 || cli_rdata_valid !== 4'b0) begin n_fail++; $display("FAIL err_set: err %b rv %b want 1 0000", arb_err, cli_rdata_valid); end
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", arb_err); end
    tick();
    set_req(0, 1'b0, 25'h77, '0, '0); cli_valid = 4'b0001; avl_ready = 1'b0;
    tick(); cli_valid = '0;
    @(negedge clk);
    n_tests++; if (avl_rd !== 1'b1) begin n_fail++; $display("FAIL rst_pre: read_req %b want 1", avl_rd); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({avl_rd, avl_wr, avl_bb, arb_err} !== 4'b0) begin n_fail++; $display("FAIL rst_async: rd/wr/bb/err %b want 0000", {avl_rd, avl_wr, avl_bb, arb_err}); end
    tick(); rst = 1'b0; tag_q.delete(); avl_ready = 1'b1;
    tick(); drive_rdata({4{32'h0BAD0BAD}});
    tick(); avl_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (arb_err !== 1'b1 || cli_rdata_valid !== 4'b0) begin n_fail++; $display("FAIL rst_fifo_empty: err %b rv %b want 1 0000", arb_err, cli_rdata_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold();
    test_full();
    test_back_to_back();
    test_err_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end
endmodule

// File: doc/mcpu_mem_arb.md
Name: mcpu_mem_arb

Overview:
- Multi-client memory arbiter directly upstream of the LPDDR2 memory controller.
- Accepts single-beat 128-bit read/write requests from NCLIENTS ports and selects one per cycle by round-robin.
- Drives the controller's Avalon command port (arb2mc_avl_*) from a one-entry registered command slot.
- Tracks outstanding reads in an in-order tag FIFO and steers returning read data to the issuing client.

Parameters:
- NCLIENTS, 4, number of client ports (2..8).
- RD_DEPTH, 8, maximum outstanding reads; power of two.
- ID_W, $clog2(NCLIENTS), client-ID width; derived, not overridable.

Ports:
- clkrst_avl_clk  in  1  sole clock; same clock as the controller's Avalon port.
- clkrst_avl_rst  in  1  reset, asynchronous, active-high.
- mc_ready  in  1  controller init/calibration done and PLL locked; no client is granted while low.
- cli_valid  in  NCLIENTS  per-client request valid.
- cli_ready  out  NCLIENTS  per-client grant; a request transfers when valid&ready.
- cli_write  in  NCLIENTS  1 = write, 0 = read.
- cli_addr  in  NCLIENTS*25  128-bit-word address; client i uses bits [25i+24:25i].
- cli_wdata  in  NCLIENTS*128  write data.
- cli_be  in  NCLIENTS*16  write byte enables.
- cli_rdata  out  128  read data, broadcast to all clients.
- cli_rdata_valid  out  NCLIENTS  one-hot read-return strobe.
- arb2mc_avl_addr_0  out  25
- arb2mc_avl_wdata_0  out  128
- arb2mc_avl_be_0  out  16
- arb2mc_avl_read_req_0  out  1
- arb2mc_avl_write_req_0  out  1
- arb2mc_avl_burstbegin_0  out  1
- arb2mc_avl_size_0  out  5  constant 5'd1.
- arb2mc_avl_ready_0  in  1  controller accepts the presented command.
- arb2mc_avl_rdata_valid_0  in  1
- arb2mc_avl_rdata_0  in  128
- arb_err  out  1  sticky: read data returned with tag FIFO empty.

Behaviour:
- Reset values:
  - all outputs 0, except arb2mc_avl_size_0 = 1.
  - cmd slot empty; RR pointer = 0; tag FIFO empty; arb_err = 0.
- Slot accept: cmd slot is "free" when empty, or when occupied and arb2mc_avl_ready_0 is high this cycle.
- Eligibility: client i is eligible when all of the following hold:
  - cli_valid[i] = 1;
  - mc_ready = 1;
  - slot free;
  - for reads only, outstanding count + slot-held reads < RD_DEPTH.
- Grant:
  - Combinational, at most one-hot.
  - Searches from the RR pointer upward, wrapping.
  - cli_ready[i] = grant[i].
- RR pointer: on any grant to client k, pointer <= (k+1) mod NCLIENTS; unchanged otherwise.
- Latency: a grant at cycle N loads the slot; the command is visible on arb2mc_* at N+1.
- Command hold:
  - read_req/write_req stay asserted with stable addr/wdata/be until arb2mc_avl_ready_0 = 1.
  - burstbegin is asserted with every command (size 1).
- Back-to-back: acceptance and a new load may occur in the same cycle, giving full throughput.
- Tag FIFO push: a read's client ID is pushed when the read is loaded into the slot, so capacity accounting is conservative.
- Tag FIFO pop:
  - On arb2mc_avl_rdata_valid_0, the head ID is popped.
  - cli_rdata_valid[head] = 1 and cli_rdata = arb2mc_avl_rdata_0, both registered (1-cycle latency).
- Simultaneous push and pop: count unchanged; both performed.
- FIFO full: reads are ineligible; writes are still granted.
- rdata_valid with FIFO empty: arb_err <= 1 (cleared only by reset); no cli_rdata_valid pulse.
- mc_ready falling: no new grants; an occupied slot keeps presenting its command.
- Reset mid-operation:
  - Slot, FIFO and pointer are cleared.
  - In-flight reads are discarded; the controller must be reset with the arbiter.
- Writes produce no response.

Decomposition:
- Package mcpu_mem_pkg:
  - constants MEM_ADDR_W = 25, MEM_DATA_W = 128, MEM_BE_W = 16, MEM_SIZE_ONE = 5'd1;
  - a typedef for the command-slot record {write, addr, wdata, be}.
- Sub-module mcpu_mem_arb_tagfifo:
  - parameterised width ID_W and depth RD_DEPTH;
  - push/pop/full/empty/count interface;
  - pointer-based RAM FIFO.

Test Plan:
- Single client 0 read at addr 0x000123, arb2mc_avl_ready_0 = 1, rdata 0xA5..A5 returned 10 cycles later -> command seen at N+1 with size=1 and burstbegin=1; cli_rdata_valid = 4'b0001 one cycle after rdata_valid, cli_rdata = 0xA5..A5.
- All 4 clients continuously valid with writes, ready = 1 -> grants rotate 0,1,2,3,0,... one per cycle; no client starved.
- arb2mc_avl_ready_0 held low 5 cycles during a write -> addr/wdata/be/write_req stable all 5 cycles; cli_ready all 0; the next grant is in the cycle ready rises.
- 8 reads issued with no data returned, then a 9th read plus a write from another client -> 9th read blocked, write granted; one rdata_valid -> 9th read granted the following cycle.
- Interleaved reads from clients 2,0,3 -> returns strobe 4'b0100, 4'b0001, 4'b1000 in order; a simultaneous new read push and data pop leaves the count unchanged.
- rdata_valid with no outstanding reads -> arb_err = 1 and stays 1; async reset mid-command -> read_req/write_req drop to 0 immediately; FIFO empty afterwards.
